// File: rtl/axi_bridge_pkg.sv
// Shared constants, tracker entry type and width helpers for axi_bridge_mp.
// No ports: package only.
package axi_bridge_pkg;

    localparam logic [1:0]  BURST_INCR = 2'b01;
    localparam logic [3:0]  LEN_SINGLE = 4'd0;
    localparam int unsigned WR_ID      = 0;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned WADDR_W   = 30;   // word address addr[31:2]
    localparam int unsigned MST_IDX_W = 8;    // room for up to 256 masters

    // One in-flight write: word address for hazard compare, owner for B steering
    typedef struct packed {
        logic [WADDR_W-1:0]   addr;
        logic [MST_IDX_W-1:0] master;
    } wr_entry_t;

    // Counter width able to hold 0..n
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Index width for n items, at least one bit
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_wr_tracker.sv
// In-order FIFO of in-flight writes with a parallel address compare per probe.
// Ports: clk/resetn; push+entry appends, pop drops head; probe[] word addresses
// return hit[] when any live entry matches (a popping head is ignored);
// full when every slot is live; head is the oldest entry.
module axi_wr_tracker
    import axi_bridge_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned N_PROBE = 2
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              push,
    input  logic                              pop,
    input  wr_entry_t                         entry,
    input  logic [N_PROBE-1:0][WADDR_W-1:0]   probe,
    output logic                              full,
    output logic [N_PROBE-1:0]                hit,
    output wr_entry_t                         head
);

    localparam int unsigned PTR_W = idx_w(DEPTH);

    wr_entry_t        mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage and pointers; a same-slot pop+push (full) leaves the slot live
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld    <= '0;
            for (int j = 0; j < int'(DEPTH); j++) mem[j] <= '0;
        end else begin
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= ptr_inc(rd_ptr);
            end
            if (push) begin
                mem[wr_ptr] <= entry;
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
        end
    end

    // Parallel compare of every probe against every live entry
    always_comb begin
        hit = '0;
        for (int p = 0; p < int'(N_PROBE); p++) begin
            for (int j = 0; j < int'(DEPTH); j++) begin
                if (vld[j] && (mem[j].addr == probe[p]) &&
                    !(pop && (rd_ptr == PTR_W'(j)))) begin
                    hit[p] = 1'b1;
                end
            end
        end
    end

    assign full = &vld;
    assign head = mem[rd_ptr];

endmodule

// File: rtl/axi_bridge_mp.sv
// N-master SRAM-like to AXI3 bridge with round-robin arbitration, per-master
// read limits and a write tracker that blocks read-after-write hazards.
// Ports: clk/resetn; m_* packed per-master request/response vectors;
// ar*/r*/aw*/w*/b* single-beat AXI3 master channels.
module axi_bridge_mp
    import axi_bridge_pkg::*;
#(
    parameter int unsigned N_MST          = 2,
    parameter int unsigned RD_OUTSTANDING = 4,
    parameter int unsigned WR_DEPTH       = 4,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ID_W           = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [N_MST-1:0]             m_req,
    input  logic [N_MST-1:0]             m_wr,
    input  logic [2*N_MST-1:0]           m_size,
    input  logic [32*N_MST-1:0]          m_addr,
    input  logic [(DATA_W/8)*N_MST-1:0]  m_wstrb,
    input  logic [DATA_W*N_MST-1:0]      m_wdata,
    output logic [N_MST-1:0]             m_addr_ok,
    output logic [N_MST-1:0]             m_data_ok,
    output logic [DATA_W-1:0]            m_rdata,
    output logic [ID_W-1:0]              arid,
    output logic [31:0]                  araddr,
    output logic [3:0]                   arlen,
    output logic [2:0]                   arsize,
    output logic [1:0]                   arburst,
    output logic [1:0]                   arlock,
    output logic [3:0]                   arcache,
    output logic [2:0]                   arprot,
    output logic                         arvalid,
    input  logic                         arready,
    input  logic [ID_W-1:0]              rid,
    input  logic [DATA_W-1:0]            rdata,
    input  logic [1:0]                   rresp,
    input  logic                         rlast,
    input  logic                         rvalid,
    output logic                         rready,
    output logic [ID_W-1:0]              awid,
    output logic [31:0]                  awaddr,
    output logic [3:0]                   awlen,
    output logic [2:0]                   awsize,
    output logic [1:0]                   awburst,
    output logic [1:0]                   awlock,
    output logic [3:0]                   awcache,
    output logic [2:0]                   awprot,
    output logic                         awvalid,
    input  logic                         awready,
    output logic [ID_W-1:0]              wid,
    output logic [DATA_W-1:0]            wdata,
    output logic [DATA_W/8-1:0]          wstrb,
    output logic                         wlast,
    output logic                         wvalid,
    input  logic                         wready,
    input  logic [ID_W-1:0]              bid,
    input  logic [1:0]                   bresp,
    input  logic                         bvalid,
    output logic                         bready
);

    localparam int unsigned CNT_W  = cnt_w(RD_OUTSTANDING);
    localparam int unsigned MST_W  = idx_w(N_MST);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [CNT_W-1:0]          rd_cnt [N_MST];
    logic [MST_W-1:0]          rr_ptr;
    logic [N_MST-1:0]          elig;
    logic [N_MST-1:0]          r_ret;
    logic [N_MST-1:0]          trk_hit;
    logic [N_MST-1:0][WADDR_W-1:0] probe;
    logic                      ar_free, aw_free, w_free, b_pop, trk_full;
    logic                      gnt_vld, gnt_wr;
    logic [MST_W-1:0]          gnt_idx;
    logic [31:0]               gnt_addr;
    logic [1:0]                gnt_size;
    logic [DATA_W-1:0]         gnt_wdata;
    logic [STRB_W-1:0]         gnt_wstrb;
    wr_entry_t                 trk_head;
    logic                      unused_ok;

    assign ar_free = ~arvalid | arready;
    assign aw_free = ~awvalid | awready;
    assign w_free  = ~wvalid | wready;
    assign b_pop   = bvalid & bready;
    // R owns data_ok of its master this cycle; a B for the same master waits
    assign bready  = ~(rvalid & (rid == ID_W'(trk_head.master)));
    assign rready  = 1'b1;
    assign m_rdata = rdata;

    // Per-master eligibility; an R return this cycle frees a read slot at once
    always_comb begin
        r_ret = '0;
        elig  = '0;
        probe = '0;
        for (int i = 0; i < int'(N_MST); i++) begin
            probe[i] = m_addr[i*32+2 +: WADDR_W];
            r_ret[i] = rvalid & (rid == ID_W'(i));
            if (m_wr[i])
                elig[i] = m_req[i] & aw_free & w_free & (~trk_full | b_pop);
            else
                elig[i] = m_req[i] & ar_free & ~trk_hit[i] &
                          ((rd_cnt[i] < CNT_W'(RD_OUTSTANDING)) | r_ret[i]);
        end
    end

    // Round-robin: first eligible master at or after rr_ptr wins
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < int'(N_MST); k++) begin
            if (!gnt_vld && elig[(int'(rr_ptr) + k) % int'(N_MST)]) begin
                gnt_vld = 1'b1;
                gnt_idx = MST_W'((int'(rr_ptr) + k) % int'(N_MST));
            end
        end
    end

    // Grant decode and payload mux
    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        gnt_wr    = 1'b0;
        gnt_addr  = '0;
        gnt_size  = '0;
        gnt_wdata = '0;
        gnt_wstrb = '0;
        for (int i = 0; i < int'(N_MST); i++) begin
            m_addr_ok[i] = gnt_vld & (gnt_idx == MST_W'(i));
            m_data_ok[i] = r_ret[i] | (b_pop & (trk_head.master == MST_IDX_W'(i)));
            if (m_addr_ok[i]) begin
                gnt_wr    = m_wr[i];
                gnt_addr  = m_addr[i*32 +: 32];
                gnt_size  = m_size[i*2 +: 2];
                gnt_wdata = m_wdata[i*DATA_W +: DATA_W];
                gnt_wstrb = m_wstrb[i*STRB_W +: STRB_W];
            end
        end
    end

    // Arbiter pointer and per-master outstanding-read counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= '0;
            for (int i = 0; i < int'(N_MST); i++) rd_cnt[i] <= '0;
        end else begin
            if (gnt_vld)
                rr_ptr <= (gnt_idx == MST_W'(N_MST - 1)) ? '0 : gnt_idx + MST_W'(1);
            for (int i = 0; i < int'(N_MST); i++) begin
                case ({m_addr_ok[i] & ~m_wr[i], r_ret[i]})
                    2'b10:   rd_cnt[i] <= rd_cnt[i] + CNT_W'(1);
                    2'b01:   rd_cnt[i] <= rd_cnt[i] - CNT_W'(1);
                    default: rd_cnt[i] <= rd_cnt[i];
                endcase
            end
        end
    end

    // AR, AW and W slots
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arvalid <= 1'b0;
            arid    <= '0;
            araddr  <= '0;
            arsize  <= '0;
            awvalid <= 1'b0;
            awaddr  <= '0;
            awsize  <= '0;
            wvalid  <= 1'b0;
            wdata   <= '0;
            wstrb   <= '0;
        end else begin
            if (gnt_vld && !gnt_wr) begin
                arvalid <= 1'b1;
                arid    <= ID_W'(gnt_idx);
                araddr  <= gnt_addr;
                arsize  <= {1'b0, gnt_size};
            end else if (arready) begin
                arvalid <= 1'b0;
            end
            if (gnt_vld && gnt_wr) begin
                awvalid <= 1'b1;
                awaddr  <= gnt_addr;
                awsize  <= {1'b0, gnt_size};
                wvalid  <= 1'b1;
                wdata   <= gnt_wdata;
                wstrb   <= gnt_wstrb;
            end else begin
                if (awready) awvalid <= 1'b0;
                if (wready)  wvalid  <= 1'b0;
            end
        end
    end

    axi_wr_tracker #(
        .DEPTH   (WR_DEPTH),
        .N_PROBE (N_MST)
    ) u_wr_tracker (
        .clk    (clk),
        .resetn (resetn),
        .push   (gnt_vld & gnt_wr),
        .pop    (b_pop),
        .entry  ({gnt_addr[31:2], MST_IDX_W'(gnt_idx)}),
        .probe  (probe),
        .full   (trk_full),
        .hit    (trk_hit),
        .head   (trk_head)
    );

    assign arlen   = LEN_SINGLE;
    assign arburst = BURST_INCR;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;
    assign awid    = ID_W'(WR_ID);
    assign awlen   = LEN_SINGLE;
    assign awburst = BURST_INCR;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;
    assign wid     = ID_W'(WR_ID);
    assign wlast   = 1'b1;

    // Response status and low address bits carry no meaning here
    assign unused_ok = ^{rresp, rlast, bid, bresp, gnt_addr[1:0]};

endmodule

// File: tb/tb_axi_bridge_mp.sv
// Directed self-checking bench for axi_bridge_mp (N_MST=2, 32-bit data).
module tb_axi_bridge_mp;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  m_req, m_wr, m_addr_ok, m_data_ok;
    logic [3:0]  m_size;
    logic [63:0] m_addr, m_wdata;
    logic [7:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic [3:0]  arid, rid, awid, wid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [3:0]  arlen, arcache, awlen, awcache, wstrb;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int n_chk  = 0;
    int n_fail = 0;

    axi_bridge_mp dut (
        .clk(clk), .resetn(resetn),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
        .m_wstrb(m_wstrb), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
        .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_m(input int i, input logic req, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        m_req[i]             = req;
        m_wr[i]              = wr;
        m_addr[i*32 +: 32]   = a;
        m_wdata[i*32 +: 32]  = d;
        m_wstrb[i*4 +: 4]    = 4'hF;
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        m_req   = '0; m_wr = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        m_size  = 4'b1010;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid  = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1;
        bvalid  = 1'b0; bid = '0; bresp = '0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_awvalid", 64'(awvalid), 64'd0);
        check("rst_wvalid",  64'(wvalid),  64'd0);
        check("rst_bready",  64'(bready),  64'd1);
        check("rst_rready",  64'(rready),  64'd1);
        check("rst_addr_ok", 64'(m_addr_ok), 64'd0);

        // Dual read: m0 then m1
        arready = 1'b1;
        set_m(0, 1'b1, 1'b0, 32'h1000, 32'h0);
        set_m(1, 1'b1, 1'b0, 32'h2000, 32'h0);
        settle();
        check("dual_ok0", 64'(m_addr_ok), 64'h1);
        step();
        m_req[0] = 1'b0;
        settle();
        check("dual_ok1", 64'(m_addr_ok), 64'h2);
        check("dual_arvalid0", 64'(arvalid), 64'd1);
        check("dual_arid0", 64'(arid), 64'd0);
        check("dual_araddr0", 64'(araddr), 64'h1000);
        step();
        m_req = '0;
        settle();
        check("dual_arid1", 64'(arid), 64'd1);
        check("dual_araddr1", 64'(araddr), 64'h2000);
        rvalid = 1'b1; rid = 4'd1; rdata = 32'hCAFE_0001;
        settle();
        check("dual_dok1", 64'(m_data_ok), 64'h2);
        check("dual_rdata", 64'(m_rdata), 64'hCAFE_0001);
        step();
        rid = 4'd0;
        settle();
        check("dual_dok0", 64'(m_data_ok), 64'h1);
        step();
        rvalid = 1'b0;

        // Backpressure on AR
        do_reset();
        set_m(0, 1'b1, 1'b0, 32'h3000, 32'h0);
        settle();
        check("bp_first_ok", 64'(m_addr_ok), 64'h1);
        step();
        m_addr[31:0] = 32'h3004;
        for (int c = 0; c < 5; c++) begin
            settle();
            check("bp_arvalid", 64'(arvalid), 64'd1);
            check("bp_araddr", 64'(araddr), 64'h3000);
            check("bp_addr_ok", 64'(m_addr_ok), 64'h0);
            step();
        end
        arready = 1'b1;
        settle();
        check("bp_release_ok", 64'(m_addr_ok), 64'h1);
        step();
        m_req = '0;
        settle();
        check("bp_next_araddr", 64'(araddr), 64'h3004);
        step();
        check("bp_idle", 64'(arvalid), 64'd0);

        // Read-after-write hazard
        do_reset();
        arready = 1'b1; awready = 1'b1; wready = 1'b1;
        set_m(1, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
        settle();
        check("raw_wr_ok", 64'(m_addr_ok), 64'h2);
        step();
        m_req[1] = 1'b0;
        set_m(0, 1'b1, 1'b0, 32'h102, 32'h0);
        settle();
        check("raw_awvalid", 64'(awvalid), 64'd1);
        check("raw_awaddr", 64'(awaddr), 64'h100);
        check("raw_wdata", 64'(wdata), 64'hDEAD_BEEF);
        check("raw_wstrb", 64'(wstrb), 64'hF);
        check("raw_blocked", 64'(m_addr_ok), 64'h0);
        step();
        for (int c = 0; c < 3; c++) begin
            settle();
            check("raw_blocked_hold", 64'(m_addr_ok), 64'h0);
            check("raw_no_ar", 64'(arvalid), 64'd0);
            step();
        end
        bvalid = 1'b1;
        settle();
        check("raw_bready", 64'(bready), 64'd1);
        check("raw_b_dok", 64'(m_data_ok), 64'h2);
        check("raw_unblock", 64'(m_addr_ok), 64'h1);
        step();
        bvalid = 1'b0;
        m_req[0] = 1'b0;
        set_m(1, 1'b1, 1'b1, 32'h100, 32'h1234_5678);
        settle();
        check("raw_arvalid", 64'(arvalid), 64'd1);
        check("raw_araddr", 64'(araddr), 64'h102);
        check("raw_wr2_ok", 64'(m_addr_ok), 64'h2);
        step();
        m_req[1] = 1'b0;
        set_m(0, 1'b1, 1'b0, 32'h104, 32'h0);
        settle();
        check("raw_other_word", 64'(m_addr_ok), 64'h1);
        step();
        m_req = '0;

        // Outstanding-read limit
        do_reset();
        arready = 1'b1;
        set_m(0, 1'b1, 1'b0, 32'h4000, 32'h0);
        for (int c = 0; c < 4; c++) begin
            settle();
            check("lim_rd_ok", 64'(m_addr_ok), 64'h1);
            step();
        end
        settle();
        check("lim_rd_fifth", 64'(m_addr_ok), 64'h0);
        rvalid = 1'b1; rid = 4'd0;
        settle();
        check("lim_rd_reenable", 64'(m_addr_ok), 64'h1);
        check("lim_rd_dok", 64'(m_data_ok), 64'h1);
        step();
        rvalid = 1'b0;
        settle();
        check("lim_rd_full_again", 64'(m_addr_ok), 64'h0);
        m_req = '0;

        // Write tracker depth limit
        do_reset();
        awready = 1'b1; wready = 1'b1;
        set_m(0, 1'b1, 1'b1, 32'h5000, 32'h55);
        for (int c = 0; c < 4; c++) begin
            settle();
            check("lim_wr_ok", 64'(m_addr_ok), 64'h1);
            step();
        end
        settle();
        check("lim_wr_fifth", 64'(m_addr_ok), 64'h0);
        bvalid = 1'b1;
        settle();
        check("lim_wr_pushpop", 64'(m_addr_ok), 64'h1);
        check("lim_wr_dok", 64'(m_data_ok), 64'h1);
        step();
        bvalid = 1'b0;
        m_req = '0;

        // R/B collision on master 1
        do_reset();
        arready = 1'b1; awready = 1'b1; wready = 1'b1;
        set_m(1, 1'b1, 1'b0, 32'h300, 32'h0);
        settle();
        check("col_rd_ok", 64'(m_addr_ok), 64'h2);
        step();
        set_m(1, 1'b1, 1'b1, 32'h200, 32'hAA);
        settle();
        check("col_wr_ok", 64'(m_addr_ok), 64'h2);
        step();
        m_req = '0;
        rvalid = 1'b1; rid = 4'd1; bvalid = 1'b1;
        settle();
        check("col_bready_low", 64'(bready), 64'd0);
        check("col_dok_r", 64'(m_data_ok), 64'h2);
        step();
        rvalid = 1'b0;
        settle();
        check("col_bready_high", 64'(bready), 64'd1);
        check("col_dok_b", 64'(m_data_ok), 64'h2);
        step();
        bvalid = 1'b0;
        settle();
        check("col_dok_idle", 64'(m_data_ok), 64'h0);

        // Reset in the middle of a write
        do_reset();
        set_m(1, 1'b1, 1'b1, 32'h600, 32'h66);
        step();
        m_req = '0;
        settle();
        check("mrst_awvalid_pre", 64'(awvalid), 64'd1);
        check("mrst_wvalid_pre", 64'(wvalid), 64'd1);
        step();
        resetn = 1'b0;
        #1;
        check("mrst_arvalid", 64'(arvalid), 64'd0);
        check("mrst_awvalid", 64'(awvalid), 64'd0);
        check("mrst_wvalid", 64'(wvalid), 64'd0);
        step();
        resetn = 1'b1;
        arready = 1'b1;
        set_m(0, 1'b1, 1'b0, 32'h600, 32'h0);
        settle();
        check("mrst_trk_empty", 64'(m_addr_ok), 64'h1);
        check("mrst_awvalid_post", 64'(awvalid), 64'd0);
        step();
        m_req = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
